ptp_rtc_adj_ctrl: RTL and testbench

- Adjustment controller in front of the real-time counter (RTC).
- Arbitrates correction requests from two sources: host register interface (h_*) and PTP servo (s_*).
- Normalizes offsets into the RTC's legal range, then sequences single-cycle offset strobes, tick increment updates and clear pulses into the RTC.
- Enforces a hold-off window after each action so the RTC's wrap-deferred adjustment logic is never re-triggered before it settles.

---
 rtl/ptp_rtc_pkg.sv | 24 ++
 rtl/ptp_rtc_adj_arb.sv | 16 +
 rtl/ptp_rtc_adj_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ptp_rtc_adj_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_rtc_pkg.sv
// Shared types and constants for the RTC adjustment controller.
package ptp_rtc_pkg;

    localparam logic [31:0] SC2NS = 32'd1000000000;
    localparam int unsigned FNS_W = 26;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        ISSUE,
        HOLD,
        CLEAR
    } adj_state_t;

    typedef struct packed {
        logic        clr;
        logic        ofs_en;
        logic        tick_wr;
        logic [31:0] ns;
        logic [47:0] sc;
        logic [31:0] tick;
    } adj_req_t;

endpackage

// File: rtl/ptp_rtc_adj_arb.sv
// Two-way round-robin arbiter; rr_ptr = 1 gives the servo priority on a tie.
module ptp_rtc_adj_arb (
    input  logic h_req,
    input  logic s_req,
    input  logic rr_ptr,
    output logic gnt_h,
    output logic gnt_s,
    output logic ptr_nxt
);

    assign gnt_h   = h_req & (~s_req | ~rr_ptr);
    assign gnt_s   = s_req & ~gnt_h;
    // after a host grant the servo wins the next tie, and vice versa
    assign ptr_nxt = gnt_h;

endmodule

// File: rtl/ptp_rtc_adj_ctrl.sv
// RTC adjustment controller: arbitrates host/servo requests, normalises offsets, sequences strobes.
// Optional per-source statistics counters enabled by defining PTP_RTC_ADJ_STAT_EN.
module ptp_rtc_adj_ctrl #(
    parameter int unsigned HOLD_CYC     = 8,
    parameter int unsigned CLR_CYC      = 4,
    parameter logic [31:0] TICK_INC_RST = 32'd8 << ptp_rtc_pkg::FNS_W,
    parameter logic [31:0] SC2NS        = ptp_rtc_pkg::SC2NS
) (
    input  logic        rtc_clk,
    input  logic        rtc_rst,
    input  logic        h_valid_i,
    output logic        h_ready_o,
    input  logic        h_clr_i,
    input  logic        h_ofs_en_i,
    input  logic        h_tick_wr_i,
    input  logic [31:0] h_ns_ofs_i,
    input  logic [47:0] h_sc_ofs_i,
    input  logic [31:0] h_tick_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic        s_ofs_en_i,
    input  logic        s_tick_wr_i,
    input  logic [31:0] s_ns_ofs_i,
    input  logic [47:0] s_sc_ofs_i,
    input  logic [31:0] s_tick_i,
    output logic [31:0] tick_inc_o,
    output logic [31:0] ns_offset_o,
    output logic [47:0] sc_offset_o,
    output logic        offset_valid_o,
    output logic        clear_rtc_o,
    output logic        busy_o,
    output logic        err_o,
    output logic        last_src_o
`ifdef PTP_RTC_ADJ_STAT_EN
    ,
    output logic [15:0] h_cnt_o,
    output logic [15:0] s_cnt_o,
    output logic [15:0] err_cnt_o
`endif
);

    import ptp_rtc_pkg::*;

    localparam logic signed [32:0] LIM1 = $signed({1'b0, SC2NS});
    localparam logic signed [32:0] LIM2 = $signed({SC2NS, 1'b0});

    adj_state_t        state, state_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic              idle, accept, issue, drop;
    logic              rr_ptr, ptr_nxt, gnt_h, gnt_s;
    adj_req_t          sel, req;
    logic signed [32:0] ns_w;
    logic [31:0]       ns_n;
    logic [47:0]       sc_n;
    logic              ns_err;

    assign idle   = (state == IDLE);
    assign busy_o = ~idle;

    ptp_rtc_adj_arb u_arb (
        .h_req   (h_valid_i & idle),
        .s_req   (s_valid_i & idle),
        .rr_ptr  (rr_ptr),
        .gnt_h   (gnt_h),
        .gnt_s   (gnt_s),
        .ptr_nxt (ptr_nxt)
    );

    assign h_ready_o = gnt_h;
    assign s_ready_o = gnt_s;
    assign accept    = gnt_h | gnt_s;
    // req.clr qualifies the level so a stale state can never clear on a non-clear request
    assign clear_rtc_o = (state == CLEAR) && req.clr;

    always_comb begin
        if (gnt_h) begin
            sel = '{clr: h_clr_i, ofs_en: h_ofs_en_i, tick_wr: h_tick_wr_i,
                    ns: h_ns_ofs_i, sc: h_sc_ofs_i, tick: h_tick_i};
        end else begin
            sel = '{clr: 1'b0, ofs_en: s_ofs_en_i, tick_wr: s_tick_wr_i,
                    ns: s_ns_ofs_i, sc: s_sc_ofs_i, tick: s_tick_i};
        end
    end

    always_comb begin
        ns_w   = $signed({req.ns[31], req.ns});
        ns_err = (ns_w >= LIM2) || (ns_w <= -LIM2);
        ns_n   = req.ns;
        sc_n   = req.sc;
        if (ns_w >= LIM1) begin
            ns_n = req.ns - SC2NS;
            sc_n = req.sc + 48'd1;
        end else if (ns_w <= -LIM1) begin
            ns_n = req.ns + SC2NS;
            sc_n = req.sc - 48'd1;
        end
    end

    always_ff @(posedge rtc_clk) begin
        if (rtc_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        issue     = 1'b0;
        drop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (sel.clr) begin
                        state_nxt = CLEAR;
                        cnt_nxt   = 16'(CLR_CYC - 1);
                    end else begin
                        state_nxt = NORM;
                    end
                end
            end
            NORM: begin
                if (ns_err) begin
                    drop      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    issue     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = HOLD;
                cnt_nxt   = 16'(HOLD_CYC - 1);
            end
            HOLD: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 16'd1;
            end
            CLEAR: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = 16'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // outputs are loaded on the NORM->ISSUE edge so they are valid during ISSUE
    always_ff @(posedge rtc_clk) begin
        if (rtc_rst) begin
            req            <= '0;
            rr_ptr         <= 1'b0;
            last_src_o     <= 1'b0;
            tick_inc_o     <= TICK_INC_RST;
            ns_offset_o    <= '0;
            sc_offset_o    <= '0;
            offset_valid_o <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            offset_valid_o <= issue & req.ofs_en;
            err_o          <= drop;
            if (accept) begin
                req        <= sel;
                rr_ptr     <= ptr_nxt;
                last_src_o <= gnt_s;
            end
            if (issue && req.tick_wr) tick_inc_o <= req.tick;
            if (issue && req.ofs_en) begin
                ns_offset_o <= ns_n;
                sc_offset_o <= sc_n;
            end
        end
    end

`ifdef PTP_RTC_ADJ_STAT_EN
    always_ff @(posedge rtc_clk) begin
        if (rtc_rst) begin
            h_cnt_o   <= '0;
            s_cnt_o   <= '0;
            err_cnt_o <= '0;
        end else begin
            if (gnt_h && h_cnt_o != '1) h_cnt_o <= h_cnt_o + 16'd1;
            if (gnt_s && s_cnt_o != '1) s_cnt_o <= s_cnt_o + 16'd1;
            if (drop && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ptp_rtc_adj_ctrl.sv
// Directed self-checking bench for ptp_rtc_adj_ctrl (default build, statistics disabled).
module tb_ptp_rtc_adj_ctrl;

    logic        rtc_clk = 1'b0;
    logic        rtc_rst = 1'b1;
    logic        h_valid_i = 1'b0, h_clr_i = 1'b0, h_ofs_en_i = 1'b0, h_tick_wr_i = 1'b0;
    logic [31:0] h_ns_ofs_i = '0, h_tick_i = '0;
    logic [47:0] h_sc_ofs_i = '0;
    logic        s_valid_i = 1'b0, s_ofs_en_i = 1'b0, s_tick_wr_i = 1'b0;
    logic [31:0] s_ns_ofs_i = '0, s_tick_i = '0;
    logic [47:0] s_sc_ofs_i = '0;
    logic        h_ready_o, s_ready_o, offset_valid_o, clear_rtc_o, busy_o, err_o, last_src_o;
    logic [31:0] tick_inc_o, ns_offset_o;
    logic [47:0] sc_offset_o;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_cnt = 0;

    ptp_rtc_adj_ctrl #(.HOLD_CYC(8), .CLR_CYC(4)) dut (
        .rtc_clk(rtc_clk), .rtc_rst(rtc_rst),
        .h_valid_i(h_valid_i), .h_ready_o(h_ready_o), .h_clr_i(h_clr_i),
        .h_ofs_en_i(h_ofs_en_i), .h_tick_wr_i(h_tick_wr_i), .h_ns_ofs_i(h_ns_ofs_i),
        .h_sc_ofs_i(h_sc_ofs_i), .h_tick_i(h_tick_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_ofs_en_i(s_ofs_en_i),
        .s_tick_wr_i(s_tick_wr_i), .s_ns_ofs_i(s_ns_ofs_i), .s_sc_ofs_i(s_sc_ofs_i),
        .s_tick_i(s_tick_i),
        .tick_inc_o(tick_inc_o), .ns_offset_o(ns_offset_o), .sc_offset_o(sc_offset_o),
        .offset_valid_o(offset_valid_o), .clear_rtc_o(clear_rtc_o), .busy_o(busy_o),
        .err_o(err_o), .last_src_o(last_src_o)
    );

    always #5 rtc_clk = ~rtc_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge rtc_clk);
            #1;
            cyc_cnt++;
        end
    endtask

    task automatic idle_inputs();
        h_valid_i = 1'b0; h_clr_i = 1'b0; h_ofs_en_i = 1'b0; h_tick_wr_i = 1'b0;
        s_valid_i = 1'b0; s_ofs_en_i = 1'b0; s_tick_wr_i = 1'b0;
    endtask

    task automatic set_host(input logic clr, input logic ofs, input logic twr,
                            input logic [31:0] ns, input logic [47:0] sc, input logic [31:0] tick);
        h_valid_i = 1'b1; h_clr_i = clr; h_ofs_en_i = ofs; h_tick_wr_i = twr;
        h_ns_ofs_i = ns; h_sc_ofs_i = sc; h_tick_i = tick;
    endtask

    task automatic set_servo(input logic ofs, input logic twr,
                             input logic [31:0] ns, input logic [47:0] sc, input logic [31:0] tick);
        s_valid_i = 1'b1; s_ofs_en_i = ofs; s_tick_wr_i = twr;
        s_ns_ofs_i = ns; s_sc_ofs_i = sc; s_tick_i = tick;
    endtask

    // Runs from the first post-acceptance cycle until busy drops; records what was seen.
    task automatic observe(output int busy_n, output int strobe_at, output int strobe_cyc,
                           output int strobes, output int errs,
                           output logic [31:0] ns, output logic [47:0] sc);
        busy_n = 0; strobe_at = -1; strobe_cyc = -1; strobes = 0; errs = 0; ns = '0; sc = '0;
        while (busy_o && busy_n < 50) begin
            if (offset_valid_o) begin
                strobes++;
                strobe_at  = busy_n;
                strobe_cyc = cyc_cnt;
                ns = ns_offset_o;
                sc = sc_offset_o;
            end
            if (err_o) errs++;
            busy_n++;
            cyc();
        end
        if (err_o) errs++;
    endtask

    task automatic test_reset();
        rtc_rst = 1'b1;
        idle_inputs();
        cyc(3);
        rtc_rst = 1'b0;
        cyc(2);
        n_chk++;
        if (tick_inc_o !== 32'h2000_0000) begin
            n_fail++; $display("FAIL reset_tick: got %h want 20000000", tick_inc_o);
        end
        n_chk++;
        if ({ns_offset_o, sc_offset_o} !== 80'h0) begin
            n_fail++; $display("FAIL reset_offsets: got ns %h sc %h want 0", ns_offset_o, sc_offset_o);
        end
        n_chk++;
        if ({offset_valid_o, clear_rtc_o, busy_o, err_o, last_src_o, h_ready_o, s_ready_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {offset_valid_o, clear_rtc_o, busy_o, err_o, last_src_o, h_ready_o, s_ready_o});
        end
    endtask

    task automatic test_servo_norm();
        int busy_n, at, sc_cyc, strobes, errs;
        logic [31:0] ns;
        logic [47:0] sc;
        set_servo(1'b1, 1'b0, 32'd1500000000, 48'd5, 32'h0);
        #1;
        n_chk++;
        if ({h_ready_o, s_ready_o} !== 2'b01) begin
            n_fail++; $display("FAIL servo_ready: got %b want 01", {h_ready_o, s_ready_o});
        end
        cyc();
        idle_inputs();
        observe(busy_n, at, sc_cyc, strobes, errs, ns, sc);
        n_chk++;
        if (strobes !== 1 || at !== 1) begin
            n_fail++; $display("FAIL servo_strobe: got count %0d at %0d want 1 at 1", strobes, at);
        end
        n_chk++;
        if (ns !== 32'd500000000 || sc !== 48'd6) begin
            n_fail++; $display("FAIL servo_norm: got ns %0d sc %0d want 500000000 6", ns, sc);
        end
        n_chk++;
        if (busy_n !== 10) begin
            n_fail++; $display("FAIL servo_busy: got %0d want 10", busy_n);
        end
        n_chk++;
        if (ns_offset_o !== 32'd500000000 || last_src_o !== 1'b1 || tick_inc_o !== 32'h2000_0000) begin
            n_fail++;
            $display("FAIL servo_after: got ns %0d src %b tick %h want 500000000 1 20000000",
                     ns_offset_o, last_src_o, tick_inc_o);
        end
    endtask

    task automatic test_host_norm();
        int busy_n, at, sc_cyc, strobes, errs;
        logic [31:0] ns;
        logic [47:0] sc;
        set_host(1'b0, 1'b1, 1'b0, -32'sd1000000000, 48'd0, 32'h0);
        #1;
        n_chk++;
        if ({h_ready_o, s_ready_o} !== 2'b10) begin
            n_fail++; $display("FAIL host_ready: got %b want 10", {h_ready_o, s_ready_o});
        end
        cyc();
        idle_inputs();
        observe(busy_n, at, sc_cyc, strobes, errs, ns, sc);
        n_chk++;
        if (strobes !== 1 || ns !== 32'd0 || sc !== 48'hFFFF_FFFF_FFFF || last_src_o !== 1'b0) begin
            n_fail++;
            $display("FAIL host_neg: got n %0d ns %h sc %h src %b want 1 0 ffffffffffff 0",
                     strobes, ns, sc, last_src_o);
        end

        set_host(1'b0, 1'b1, 1'b0, 32'd2000000000, 48'd3, 32'h0);
        cyc();
        idle_inputs();
        observe(busy_n, at, sc_cyc, strobes, errs, ns, sc);
        n_chk++;
        if (errs !== 1 || strobes !== 0 || busy_n !== 1) begin
            n_fail++;
            $display("FAIL host_err_pos: got err %0d strobes %0d busy %0d want 1 0 1", errs, strobes, busy_n);
        end
        n_chk++;
        if (ns_offset_o !== 32'd0 || sc_offset_o !== 48'hFFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL host_err_keep: got ns %h sc %h want 0 ffffffffffff", ns_offset_o, sc_offset_o);
        end
        cyc();
        n_chk++;
        if (err_o !== 1'b0) begin
            n_fail++; $display("FAIL err_pulse_width: got %b want 0", err_o);
        end

        set_host(1'b0, 1'b1, 1'b0, 32'd1999999999, 48'hFFFF_FFFF_FFFF, 32'h0);
        cyc();
        idle_inputs();
        observe(busy_n, at, sc_cyc, strobes, errs, ns, sc);
        n_chk++;
        if (strobes !== 1 || errs !== 0 || ns !== 32'd999999999 || sc !== 48'd0) begin
            n_fail++;
            $display("FAIL host_wrap: got n %0d e %0d ns %0d sc %h want 1 0 999999999 0", strobes, errs, ns, sc);
        end

        set_host(1'b0, 1'b1, 1'b0, -32'sd2000000000, 48'd0, 32'h0);
        cyc();
        idle_inputs();
        observe(busy_n, at, sc_cyc, strobes, errs, ns, sc);
        n_chk++;
        if (errs !== 1 || strobes !== 0) begin
            n_fail++; $display("FAIL host_err_neg: got err %0d strobes %0d want 1 0", errs, strobes);
        end
    endtask

    task automatic test_back_to_back();
        int busy_n, at, c1, c2, strobes, errs;
        logic [31:0] ns;
        logic [47:0] sc;
        rtc_rst = 1'b1;
        cyc();
        rtc_rst = 1'b0;
        cyc();
        set_host(1'b0, 1'b1, 1'b0, 32'd100, 48'd1, 32'h0);
        set_servo(1'b1, 1'b0, 32'd200, 48'd2, 32'h0);
        #1;
        n_chk++;
        if ({h_ready_o, s_ready_o} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_grant1: got %b want 10", {h_ready_o, s_ready_o});
        end
        cyc();
        idle_inputs();
        observe(busy_n, at, c1, strobes, errs, ns, sc);
        n_chk++;
        if (ns !== 32'd100 || sc !== 48'd1) begin
            n_fail++; $display("FAIL b2b_data1: got ns %0d sc %0d want 100 1", ns, sc);
        end
        set_host(1'b0, 1'b1, 1'b0, 32'd100, 48'd1, 32'h0);
        set_servo(1'b1, 1'b0, 32'd200, 48'd2, 32'h0);
        #1;
        n_chk++;
        if ({h_ready_o, s_ready_o} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_grant2: got %b want 01", {h_ready_o, s_ready_o});
        end
        cyc();
        idle_inputs();
        observe(busy_n, at, c2, strobes, errs, ns, sc);
        n_chk++;
        if (ns !== 32'd200 || sc !== 48'd2 || last_src_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_data2: got ns %0d sc %0d src %b want 200 2 1", ns, sc, last_src_o);
        end
        n_chk++;
        if (c2 - c1 !== 11) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d want 11", c2 - c1);
        end
    endtask

    task automatic test_clear();
        int clr_n = 0, hold_n = 0, early = 0, ov_n = 0;
        set_host(1'b1, 1'b1, 1'b1, 32'd5, 48'd5, 32'h1234_5678);
        #1;
        n_chk++;
        if (h_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL clr_ready: got %b want 1", h_ready_o);
        end
        cyc();
        idle_inputs();
        set_servo(1'b0, 1'b0, 32'd0, 48'd0, 32'h0);
        while (busy_o && clr_n + hold_n < 50) begin
            if (clear_rtc_o) clr_n++;
            else hold_n++;
            if (s_ready_o) early++;
            if (offset_valid_o) ov_n++;
            cyc();
        end
        n_chk++;
        if (clr_n !== 4 || hold_n !== 8) begin
            n_fail++; $display("FAIL clr_timing: got clear %0d hold %0d want 4 8", clr_n, hold_n);
        end
        n_chk++;
        if (early !== 0 || ov_n !== 0) begin
            n_fail++; $display("FAIL clr_quiet: got ready %0d strobes %0d want 0 0", early, ov_n);
        end
        n_chk++;
        if (s_ready_o !== 1'b1 || clear_rtc_o !== 1'b0 || tick_inc_o !== 32'h2000_0000) begin
            n_fail++;
            $display("FAIL clr_end: got ready %b clear %b tick %h want 1 0 20000000",
                     s_ready_o, clear_rtc_o, tick_inc_o);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_tick_rst();
        int bad = 0;
        set_servo(1'b0, 1'b1, 32'd5, 48'd1, 32'h2000_0400);
        #1;
        n_chk++;
        if (s_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL tick_ready: got %b want 1", s_ready_o);
        end
        cyc();
        idle_inputs();
        n_chk++;
        if (tick_inc_o !== 32'h2000_0000) begin
            n_fail++; $display("FAIL tick_norm: got %h want 20000000", tick_inc_o);
        end
        cyc();
        n_chk++;
        if (tick_inc_o !== 32'h2000_0400 || offset_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL tick_issue: got tick %h ov %b want 20000400 0", tick_inc_o, offset_valid_o);
        end
        cyc(3);
        n_chk++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL tick_hold: got busy %b want 1", busy_o);
        end
        rtc_rst = 1'b1;
        cyc();
        n_chk++;
        if (tick_inc_o !== 32'h2000_0000 || busy_o !== 1'b0 || last_src_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_reset: got tick %h busy %b src %b want 20000000 0 0", tick_inc_o, busy_o, last_src_o);
        end
        rtc_rst = 1'b0;
        repeat (12) begin
            if (offset_valid_o || clear_rtc_o || busy_o || err_o) bad++;
            cyc();
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL tick_post_reset: got %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_servo_norm();
        test_host_norm();
        test_back_to_back();
        test_clear();
        test_tick_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
